// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC sequencer and its surroundings.
package mac_pkg;

    localparam int LEN_W = 16;
    localparam int FP_W  = 32;

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        WAIT_RES = 2'd1,
        PUSH     = 2'd2
    } mac_state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Pops operand pairs in lock-step, tags vector boundaries for the MAC core and
// pushes each accumulated result to the host FIFO under backpressure.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned VEC_LEN = 128,
    parameter int          LEN_W   = mac_pkg::LEN_W
) (
    input  logic             bus_clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_vec_len,

    input  logic             fifo_host_to_fpga_empty_1st,
    input  logic             fifo_host_to_fpga_empty_2nd,
    output logic             fifo_host_to_fpga_rden_1st,
    output logic             fifo_host_to_fpga_rden_2nd,
    input  logic [FP_W-1:0]  fifo_host_to_fpga_dout_1st,
    input  logic [FP_W-1:0]  fifo_host_to_fpga_dout_2nd,

    output logic             mac_in_valid,
    output logic [FP_W-1:0]  mac_a,
    output logic [FP_W-1:0]  mac_b,
    output logic             mac_first,
    output logic             mac_last,
    input  logic             mac_out_valid,
    input  logic [FP_W-1:0]  mac_result,

    output logic             fifo_fpga_to_host_wren,
    input  logic             fifo_fpga_to_host_full,
    output logic [FP_W-1:0]  fifo_fpga_to_host_din,

    output logic             busy,
    output logic [31:0]      vec_done,
    output logic             err_stray
);

    mac_state_t       state_q;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cur_len;
    logic             in_valid_q;
    logic             first_q;
    logic             last_q;
    logic [FP_W-1:0]  din_q;
    logic [31:0]      vec_done_q;
    logic             err_stray_q;
    logic             pop;
    logic             is_last;

    // NOTE: rden must be combinational from the empty flags so a pop lands in
    // the same cycle both FIFOs are seen non-empty; a registered rden would
    // over-read a FIFO that just went empty.
    assign pop = !rst && (state_q == ISSUE)
              && !fifo_host_to_fpga_empty_1st && !fifo_host_to_fpga_empty_2nd;

    // At index 0 the length comes live from the register; later elements use
    // the value latched at the vector start.
    always_comb begin
        cur_len = len_q;
        if (idx_q == '0)
            cur_len = (cfg_vec_len == '0) ? LEN_W'(VEC_LEN) : cfg_vec_len;
    end

    assign is_last = (idx_q == (cur_len - LEN_W'(1)));

    // NOTE: every register, the result data included, is cleared by the
    // synchronous reset so all outputs read 0 while rst is high.
    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state_q     <= ISSUE;
            idx_q       <= '0;
            len_q       <= '0;
            in_valid_q  <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            din_q       <= '0;
            vec_done_q  <= '0;
            err_stray_q <= 1'b0;
        end else begin
            in_valid_q <= pop;
            first_q    <= pop && (idx_q == '0);
            last_q     <= pop && is_last;

            if (mac_out_valid && (state_q != WAIT_RES))
                err_stray_q <= 1'b1;

            case (state_q)
                ISSUE: begin
                    if (pop) begin
                        if (idx_q == '0)
                            len_q <= cur_len;
                        if (is_last) begin
                            idx_q   <= '0;
                            state_q <= WAIT_RES;
                        end else begin
                            idx_q <= idx_q + LEN_W'(1);
                        end
                    end
                end
                WAIT_RES: begin
                    if (mac_out_valid) begin
                        din_q   <= mac_result;
                        state_q <= PUSH;
                    end
                end
                PUSH: begin
                    if (!fifo_fpga_to_host_full) begin
                        vec_done_q <= vec_done_q + 32'd1;
                        state_q    <= ISSUE;
                    end
                end
                default: state_q <= ISSUE;
            endcase
        end
    end

    assign fifo_host_to_fpga_rden_1st = pop;
    assign fifo_host_to_fpga_rden_2nd = pop;

    // Operand data is the FIFO dout of the cycle after the pop, zero otherwise.
    assign mac_in_valid = in_valid_q;
    assign mac_a        = in_valid_q ? fifo_host_to_fpga_dout_1st : '0;
    assign mac_b        = in_valid_q ? fifo_host_to_fpga_dout_2nd : '0;
    assign mac_first    = first_q;
    assign mac_last     = last_q;

    assign fifo_fpga_to_host_wren = (state_q == PUSH) && !fifo_fpga_to_host_full;
    assign fifo_fpga_to_host_din  = din_q;

    assign busy      = (state_q != ISSUE) || (idx_q != '0);
    assign vec_done  = vec_done_q;
    assign err_stray = err_stray_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with behavioural operand FIFOs and a
// fixed-latency MAC stand-in.
module tb_mac_seq_ctrl;

    logic        bus_clk;
    logic        rst;
    logic [15:0] cfg_vec_len;
    logic        empty_a, empty_b, rden_a, rden_b;
    logic [31:0] dout_a, dout_b;
    logic        mac_in_valid, mac_first, mac_last, mac_out_valid;
    logic [31:0] mac_a, mac_b, mac_result;
    logic        wren, full;
    logic [31:0] din;
    logic        busy;
    logic [31:0] vec_done;
    logic        err_stray;

    mac_seq_ctrl dut (
        .bus_clk                     (bus_clk),
        .rst                         (rst),
        .cfg_vec_len                 (cfg_vec_len),
        .fifo_host_to_fpga_empty_1st (empty_a),
        .fifo_host_to_fpga_empty_2nd (empty_b),
        .fifo_host_to_fpga_rden_1st  (rden_a),
        .fifo_host_to_fpga_rden_2nd  (rden_b),
        .fifo_host_to_fpga_dout_1st  (dout_a),
        .fifo_host_to_fpga_dout_2nd  (dout_b),
        .mac_in_valid                (mac_in_valid),
        .mac_a                       (mac_a),
        .mac_b                       (mac_b),
        .mac_first                   (mac_first),
        .mac_last                    (mac_last),
        .mac_out_valid               (mac_out_valid),
        .mac_result                  (mac_result),
        .fifo_fpga_to_host_wren      (wren),
        .fifo_fpga_to_host_full      (full),
        .fifo_fpga_to_host_din       (din),
        .busy                        (busy),
        .vec_done                    (vec_done),
        .err_stray                   (err_stray)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    // Standard (non-FWFT) operand FIFOs: data appears the cycle after rden.
    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];
    int wp_a = 0, wp_b = 0, rp_a = 0, rp_b = 0;
    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);

    always @(posedge bus_clk) begin
        if (rden_a && !empty_a) begin
            dout_a <= mem_a[rp_a];
            rp_a   <= rp_a + 1;
        end
        if (rden_b && !empty_b) begin
            dout_b <= mem_b[rp_b];
            rp_b   <= rp_b + 1;
        end
    end

    // MAC stand-in: result pulse four cycles after the last element.
    logic [3:0]  last_pipe;
    logic        stray;
    logic [31:0] res_base;
    always @(posedge bus_clk) begin
        if (rst) last_pipe <= 4'b0;
        else     last_pipe <= {last_pipe[2:0], mac_in_valid && mac_last};
    end
    assign mac_out_valid = last_pipe[3] | stray;
    assign mac_result    = res_base;

    // Monitor: counts events and checks first/last tagging against position.
    int n_rden = 0, n_valid = 0, n_first = 0, n_last = 0, n_wren = 0, n_mov = 0;
    int first_bad = 0, skew_bad = 0, underflow = 0, vec_pos = 0, last_len = 0;
    logic [31:0] wr_data, a_first, b_first, a_last, b_last;

    always @(posedge bus_clk) begin
        if (rden_a !== rden_b) skew_bad <= skew_bad + 1;
        if ((rden_a && empty_a) || (rden_b && empty_b)) underflow <= underflow + 1;
        if (rden_a) n_rden <= n_rden + 1;
        if (wren) begin
            n_wren  <= n_wren + 1;
            wr_data <= din;
        end
        if (mac_out_valid) n_mov <= n_mov + 1;
        if (rst) begin
            vec_pos <= 0;
        end else if (mac_in_valid) begin
            n_valid <= n_valid + 1;
            if (mac_first != (vec_pos == 0)) first_bad <= first_bad + 1;
            if (mac_first) begin
                n_first <= n_first + 1;
                a_first <= mac_a;
                b_first <= mac_b;
            end
            if (mac_last) begin
                n_last   <= n_last + 1;
                last_len <= vec_pos + 1;
                a_last   <= mac_a;
                b_last   <= mac_b;
                vec_pos  <= 0;
            end else begin
                vec_pos <= vec_pos + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge bus_clk);
    endtask

    task automatic push_a(input logic [31:0] d);
        mem_a[wp_a] = d;
        wp_a++;
    endtask

    task automatic push_b(input logic [31:0] d);
        mem_b[wp_b] = d;
        wp_b++;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        push_a(a);
        push_b(b);
    endtask

    task automatic wait_wren(input int target, input string tag);
        int k = 0;
        while (n_wren < target && k < 2000) begin
            @(negedge bus_clk);
            k++;
        end
        checks++;
        assert (n_wren >= target)
        else begin
            errors++;
            $error("FAIL %s: timeout, observed %0d writes expected %0d", tag, n_wren, target);
        end
        @(negedge bus_clk);
    endtask

    int base_rden, base_first, base_last, base_wren, base_mov, k;

    initial begin
        rst = 1'b1; cfg_vec_len = 16'd3; full = 1'b0; stray = 1'b0; res_base = '0;
        tick(3);
        chk1 ("rst_in_valid", mac_in_valid, 1'b0);
        chk1 ("rst_rden",     rden_a,       1'b0);
        chk1 ("rst_first",    mac_first,    1'b0);
        chk1 ("rst_last",     mac_last,     1'b0);
        chk1 ("rst_wren",     wren,         1'b0);
        chk1 ("rst_busy",     busy,         1'b0);
        chk1 ("rst_err",      err_stray,    1'b0);
        chk32("rst_vec_done", vec_done,     32'd0);
        chk32("rst_din",      din,          32'd0);
        rst = 1'b0;
        tick(1);

        // Basic vector: 1*4 + 2*5 + 3*6 = 32.0
        res_base = 32'h4200_0000;
        push_pair(32'h3F80_0000, 32'h4080_0000);
        push_pair(32'h4000_0000, 32'h40A0_0000);
        push_pair(32'h4040_0000, 32'h40C0_0000);
        wait_wren(1, "basic_wait");
        chk32("basic_data",     wr_data,  32'h4200_0000);
        chk32("basic_vec_done", vec_done, 32'd1);
        chk32("basic_len",      last_len, 32'd3);
        chk32("basic_first_n",  n_first,  32'd1);
        chk32("basic_last_n",   n_last,   32'd1);
        chk32("basic_a_first",  a_first,  32'h3F80_0000);
        chk32("basic_b_first",  b_first,  32'h4080_0000);
        chk32("basic_a_last",   a_last,   32'h4040_0000);
        chk32("basic_b_last",   b_last,   32'h40C0_0000);
        chk32("basic_valid_n",  n_valid,  32'd3);
        chk1 ("basic_busy",     busy,     1'b0);

        // Skewed inputs, plus a length change after the vector has started
        cfg_vec_len = 16'd5;
        res_base    = 32'hC0DE_0005;
        base_rden   = n_rden;
        for (int i = 0; i < 5; i++) push_a(32'h1000 + 32'(i));
        tick(6);
        chk32("skew_no_pop", n_rden - base_rden, 32'd0);
        chk1 ("skew_idle",   busy, 1'b0);
        push_b(32'h2000);
        tick(3);
        chk32("skew_one_pop", n_rden - base_rden, 32'd1);
        chk1 ("skew_busy",    busy, 1'b1);
        cfg_vec_len = 16'd3;
        for (int i = 1; i < 5; i++) push_b(32'h2000 + 32'(i));
        wait_wren(2, "skew_wait");
        chk32("skew_pops",     n_rden - base_rden, 32'd5);
        chk32("skew_len",      last_len, 32'd5);
        chk32("skew_data",     wr_data,  32'hC0DE_0005);
        chk32("skew_vec_done", vec_done, 32'd2);

        // Backpressure: result held while the host FIFO is full
        full     = 1'b1;
        res_base = 32'h1234_5678;
        base_mov = n_mov;
        for (int i = 0; i < 3; i++) push_pair(32'h3000 + 32'(i), 32'h4000 + 32'(i));
        k = 0;
        while (n_mov == base_mov && k < 200) begin
            tick(1);
            k++;
        end
        chk1("bp_result_seen", (n_mov != base_mov), 1'b1);
        base_wren = n_wren;
        for (int i = 0; i < 10; i++) begin
            chk32("bp_din_held", din,  32'h1234_5678);
            chk1 ("bp_no_wren",  wren, 1'b0);
            tick(1);
        end
        chk32("bp_no_write", n_wren - base_wren, 32'd0);
        full = 1'b0;
        #1;
        chk1("bp_wren_on_release", wren, 1'b1);
        wait_wren(3, "bp_wait");
        chk32("bp_one_write",  n_wren - base_wren, 32'd1);
        chk32("bp_vec_done",   vec_done, 32'd3);
        chk1 ("bp_wren_after", wren, 1'b0);

        // Length 0 selects the 128-element default
        cfg_vec_len = 16'd0;
        res_base    = 32'h3F00_0080;
        for (int i = 0; i < 128; i++) push_pair(32'(i), 32'(i + 1000));
        wait_wren(4, "len0_wait");
        chk32("len0_len",      last_len, 32'd128);
        chk32("len0_vec_done", vec_done, 32'd4);
        chk32("len0_data",     wr_data,  32'h3F00_0080);

        // Length 1: every element is both first and last
        cfg_vec_len = 16'd1;
        res_base    = 32'h55AA_0001;
        base_first  = n_first;
        base_last   = n_last;
        for (int i = 0; i < 4; i++) push_pair(32'h5000 + 32'(i), 32'h6000 + 32'(i));
        wait_wren(8, "len1_wait");
        chk32("len1_first_n",  n_first - base_first, 32'd4);
        chk32("len1_last_n",   n_last - base_last,   32'd4);
        chk32("len1_len",      last_len, 32'd1);
        chk32("len1_vec_done", vec_done, 32'd8);

        // Reset mid-vector discards the partial vector
        cfg_vec_len = 16'd3;
        base_wren   = n_wren;
        push_pair(32'h7000, 32'h8000);
        push_pair(32'h7001, 32'h8001);
        tick(4);
        chk1 ("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick(2);
        chk1 ("mid_rst_busy",     busy,         1'b0);
        chk1 ("mid_rst_in_valid", mac_in_valid, 1'b0);
        chk1 ("mid_rst_wren",     wren,         1'b0);
        chk32("mid_rst_din",      din,          32'd0);
        chk32("mid_rst_vec_done", vec_done,     32'd0);
        rst = 1'b0;
        tick(2);
        chk32("mid_no_write", n_wren - base_wren, 32'd0);
        res_base = 32'h0A0B_0C0D;
        for (int i = 0; i < 3; i++) push_pair(32'h7100 + 32'(i), 32'h8100 + 32'(i));
        wait_wren(base_wren + 1, "mid_wait");
        chk32("mid_len",       last_len, 32'd3);
        chk32("mid_vec_done",  vec_done, 32'd1);
        chk32("mid_data",      wr_data,  32'h0A0B_0C0D);
        chk1 ("mid_err_clear", err_stray, 1'b0);

        // Stray result in ISSUE is sticky until reset
        tick(1);
        stray = 1'b1;
        tick(1);
        stray = 1'b0;
        chk1("stray_set", err_stray, 1'b1);
        tick(5);
        chk1("stray_held", err_stray, 1'b1);
        chk1("stray_idle", busy, 1'b0);
        rst   = 1'b1;
        stray = 1'b1;
        tick(1);
        stray = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk1 ("stray_during_rst", err_stray, 1'b0);
        chk32("stray_vec_done",   vec_done,  32'd0);

        chk32("rden_lockstep",  skew_bad,  32'd0);
        chk32("no_underflow",   underflow, 32'd0);
        chk32("first_tagging",  first_bad, 32'd0);
        chk32("valid_per_pop",  n_valid,   n_rden);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
